// File: rtl/varwidth_fifo_pkg.sv
// Shared definitions for the variable-width capture buffer: geometry defaults,
// read-engine state/phase encodings and the pre-trigger clamp helper.
package varwidth_fifo_pkg;

  localparam int ADDR_WIDTH       = 11;
  localparam int WR_DATA_WIDTH    = 10;
  localparam int WR_DATA_PER_ADDR = 3;
  localparam int WR_PAD_WIDTH     = 2;
  localparam int W = WR_DATA_WIDTH * WR_DATA_PER_ADDR + WR_PAD_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } rd_state_e;

  typedef enum logic {
    PH_CIRC = 1'b0,
    PH_MAIN = 1'b1
  } phase_e;

  typedef struct packed {
    rd_state_e state;
    phase_e    phase;
  } rd_dbg_t;

  // Pre-trigger count can never exceed the total drain length.
  function automatic logic [31:0] clamp_pre(input logic [31:0] pre, input logic [31:0] total);
    return (pre > total) ? total : pre;
  endfunction

endpackage

// File: rtl/varwidth_word_unpacker.sv
// Holds one BRAM word and selects the sample in slot ws; pad MSBs are dropped
// at load time since no slot ever reaches them.
module varwidth_word_unpacker #(
  parameter int DATA_WIDTH = 10,
  parameter int PER_ADDR   = 3,
  parameter int PAD_WIDTH  = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         load,
  input  logic [DATA_WIDTH*PER_ADDR+PAD_WIDTH-1:0]     word_in,
  input  logic [4:0]                                   ws,
  output logic [DATA_WIDTH-1:0]                        sample_out
);

  localparam int PAYLOAD_W = DATA_WIDTH * PER_ADDR;
  localparam int WORD_W    = PAYLOAD_W + PAD_WIDTH;

  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic                 unused_pad;

  assign unused_pad = ^word_in[WORD_W-1:PAYLOAD_W];

  always_comb begin
    payload_d = payload_q;
    if (load) payload_d = word_in[PAYLOAD_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) payload_q <= '0;
    else      payload_q <= payload_d;
  end

  always_comb begin
    sample_out = '0;
    for (int k = 0; k < PER_ADDR; k++) begin
      if (ws == 5'(k)) sample_out = payload_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/varwidth_fifo_reader.sv
// Drains the capture BRAM in time order: circular pre-trigger region from its
// oldest sample, then the linear post-trigger region, one sample per accept.
module varwidth_fifo_reader
  import varwidth_fifo_pkg::*;
#(
  parameter int addr_width       = ADDR_WIDTH,
  parameter int wr_data_width    = WR_DATA_WIDTH,
  parameter int wr_data_per_addr = WR_DATA_PER_ADDR,
  parameter int wr_pad_width     = WR_PAD_WIDTH
) (
  input  logic                                                      rd_clk,
  input  logic                                                      rst,
  input  logic                                                      cfg_start,
  input  logic [addr_width-1:0]                                     cfg_first_addr,
  input  logic [4:0]                                                cfg_first_ws,
  input  logic [addr_width-1:0]                                     cfg_max_circ_addr,
  input  logic [4:0]                                                cfg_max_circ_ws,
  input  logic [31:0]                                               cfg_pre_samples,
  input  logic [31:0]                                               cfg_total_samples,
  output logic                                                      bram_en,
  output logic [addr_width-1:0]                                     bram_addr,
  input  logic [wr_data_width*wr_data_per_addr+wr_pad_width-1:0]    bram_word,
  output logic [wr_data_width-1:0]                                  smp_data,
  output logic                                                      smp_valid,
  input  logic                                                      smp_ready,
  output logic                                                      smp_last,
  output logic                                                      busy,
  output logic                                                      done,
  output logic                                                      err_cfg
);

  localparam logic [4:0] LAST_WS = 5'(wr_data_per_addr - 1);

  // Stream handshake: a sample transfers on any rising edge where smp_valid and
  // smp_ready are both high; smp_data/smp_last never change while valid waits.
  rd_state_e              state_q, state_d;
  phase_e                 phase_q, phase_d;
  logic [addr_width-1:0]  addr_q, addr_d;
  logic [addr_width-1:0]  max_addr_q, max_addr_d;
  logic [4:0]             ws_q, ws_d;
  logic [4:0]             max_ws_q, max_ws_d;
  logic [31:0]            remaining_q, remaining_d;
  logic [31:0]            pre_rem_q, pre_rem_d;
  logic                   err_q, err_d;
  logic                   done_q, done_d;

  logic [31:0]            pre_eff;
  logic [addr_width-1:0]  next_addr;
  logic [4:0]             next_ws;
  phase_e                 next_phase;
  logic                   accept;
  rd_dbg_t                dbg_unused;

  // State/phase snapshot for hierarchical observation.
  assign dbg_unused = '{state: state_q, phase: phase_q};

  assign bram_en   = (state_q == ST_FETCH);
  assign bram_addr = bram_en ? addr_q : '0;
  assign smp_valid = (state_q == ST_EMIT);
  assign smp_last  = smp_valid && (remaining_q == 32'd1);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err_cfg   = err_q;
  assign accept    = smp_valid && smp_ready;

  varwidth_word_unpacker #(
    .DATA_WIDTH (wr_data_width),
    .PER_ADDR   (wr_data_per_addr),
    .PAD_WIDTH  (wr_pad_width)
  ) u_unpacker (
    .clk        (rd_clk),
    .rst        (rst),
    .load       (state_q == ST_WAIT),
    .word_in    (bram_word),
    .ws         (ws_q),
    .sample_out (smp_data)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_d      = addr_q;
    ws_d        = ws_q;
    max_addr_d  = max_addr_q;
    max_ws_d    = max_ws_q;
    remaining_d = remaining_q;
    pre_rem_d   = pre_rem_q;
    err_d       = err_q;
    done_d      = (state_q == ST_DONE);
    pre_eff     = '0;
    next_addr   = addr_q;
    next_ws     = ws_q;
    next_phase  = phase_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          pre_eff     = clamp_pre(cfg_pre_samples, cfg_total_samples);
          err_d       = (cfg_pre_samples > cfg_total_samples);
          max_addr_d  = cfg_max_circ_addr;
          max_ws_d    = cfg_max_circ_ws;
          remaining_d = cfg_total_samples;
          pre_rem_d   = pre_eff;
          if (pre_eff == 32'd0) begin
            addr_d  = cfg_max_circ_addr + addr_width'(1);
            ws_d    = '0;
            phase_d = PH_MAIN;
          end else begin
            addr_d  = cfg_first_addr;
            ws_d    = cfg_first_ws;
            phase_d = PH_CIRC;
          end
          state_d = (cfg_total_samples == 32'd0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_EMIT;
      ST_EMIT: begin
        if (accept) begin
          remaining_d = remaining_q - 32'd1;
          if (phase_q == PH_CIRC) begin
            pre_rem_d = pre_rem_q - 32'd1;
            if (pre_rem_q == 32'd1) begin
              next_addr  = max_addr_q + addr_width'(1);
              next_ws    = '0;
              next_phase = PH_MAIN;
            end else if (addr_q == max_addr_q && ws_q == max_ws_q) begin
              next_addr = '0;
              next_ws   = '0;
            end else if (ws_q == LAST_WS) begin
              next_addr = addr_q + addr_width'(1);
              next_ws   = '0;
            end else begin
              next_ws = ws_q + 5'd1;
            end
          end else begin
            if (ws_q == LAST_WS) begin
              next_addr = addr_q + addr_width'(1);
              next_ws   = '0;
            end else begin
              next_ws = ws_q + 5'd1;
            end
          end
          addr_d  = next_addr;
          ws_d    = next_ws;
          phase_d = next_phase;
          // A new word (or a region switch) needs a fresh BRAM read.
          if (remaining_q == 32'd1)
            state_d = ST_DONE;
          else if (next_addr != addr_q || next_phase != phase_q)
            state_d = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_CIRC;
      addr_q      <= '0;
      ws_q        <= '0;
      max_addr_q  <= '0;
      max_ws_q    <= '0;
      remaining_q <= '0;
      pre_rem_q   <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_q      <= addr_d;
      ws_q        <= ws_d;
      max_addr_q  <= max_addr_d;
      max_ws_q    <= max_ws_d;
      remaining_q <= remaining_d;
      pre_rem_q   <= pre_rem_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

endmodule
